tape_player: RTL and testbench



---
 rtl/tape_player.sv | 191 +++++++++++++++++++
 tb/tb_tape_player.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tape_player.sv
// Cassette playback source: streams bytes from the download buffer and
// phase-encodes each bit (MSB first) onto tapein, prefetching one byte ahead.
module tape_player #(
    parameter int HALF_DIV = 7680
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        play,
    input  logic        rewind,
    input  logic [19:0] tape_size,
    output logic [19:0] buff_addr,
    output logic        buff_read,
    input  logic        buff_ack,
    input  logic [7:0]  buff_din,
    output logic        tapein,
    output logic        active,
    output logic        done
);

    localparam int              CNT_W   = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HALF_DIV - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_PLAY, S_END} state_t;

    state_t           state_q, state_d;
    logic [19:0]      len_q, len_d;
    logic [19:0]      addr_q, addr_d;
    logic             read_q, read_d;
    logic             pf_pend_q, pf_pend_d;
    logic [7:0]       hold_q, hold_d;
    logic             hold_valid_q, hold_valid_d;
    logic [7:0]       shift_q, shift_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic             half_q, half_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tapein_q, tapein_d;
    logic             done_q, done_d;

    logic        fetch_done;
    logic [20:0] next_addr;
    logic        more_bytes;
    logic [7:0]  hold_byte;
    logic [2:0]  idx_m1;

    assign fetch_done = read_q & buff_ack;
    assign next_addr  = {1'b0, addr_q} + 21'd1;
    assign more_bytes = next_addr < {1'b0, len_q};
    // A prefetch landing exactly on the byte boundary is used directly.
    assign hold_byte  = hold_valid_q ? hold_q : buff_din;
    assign idx_m1     = bit_idx_q - 3'd1;

    always_comb begin
        // NOTE: every _d gets its _q as default so no path through the case infers a latch.
        state_d      = state_q;
        len_d        = len_q;
        addr_d       = addr_q;
        read_d       = read_q;
        pf_pend_d    = pf_pend_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        shift_d      = shift_q;
        bit_idx_d    = bit_idx_q;
        half_d       = half_q;
        cnt_d        = cnt_q;
        tapein_d     = tapein_q;
        done_d       = done_q;

        if (fetch_done) begin
            read_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (play && tape_size != '0) begin
                    len_d   = tape_size;
                    addr_d  = '0;
                    read_d  = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (fetch_done) begin
                    shift_d   = buff_din;
                    bit_idx_d = 3'd7;
                    half_d    = 1'b0;
                    cnt_d     = '0;
                    tapein_d  = ~buff_din[7];
                    pf_pend_d = 1'b1;
                    state_d   = S_PLAY;
                end
            end
            S_PLAY: begin
                // The prefetch request goes out one cycle after a byte is loaded,
                // so buff_read always drops between requests.
                if (pf_pend_q) begin
                    pf_pend_d = 1'b0;
                    if (more_bytes) begin
                        addr_d = next_addr[19:0];
                        read_d = 1'b1;
                    end
                end
                if (fetch_done) begin
                    hold_d       = buff_din;
                    hold_valid_d = 1'b1;
                end
                if (play) begin
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end else begin
                        cnt_d = '0;
                        if (!half_q) begin
                            half_d   = 1'b1;
                            tapein_d = shift_q[bit_idx_q];
                        end else if (bit_idx_q != 3'd0) begin
                            half_d    = 1'b0;
                            bit_idx_d = idx_m1;
                            tapein_d  = ~shift_q[idx_m1];
                        end else if (hold_valid_q || fetch_done) begin
                            shift_d      = hold_byte;
                            hold_valid_d = 1'b0;
                            bit_idx_d    = 3'd7;
                            half_d       = 1'b0;
                            tapein_d     = ~hold_byte[7];
                            pf_pend_d    = 1'b1;
                        end else if (read_q) begin
                            state_d = S_WAIT;
                        end else begin
                            tapein_d = 1'b0;
                            done_d   = 1'b1;
                            state_d  = S_END;
                        end
                    end
                end
            end
            S_END: begin
            end
            default: state_d = S_IDLE;
        endcase

        if (rewind) begin
            state_d      = S_IDLE;
            addr_d       = '0;
            read_d       = 1'b0;
            pf_pend_d    = 1'b0;
            hold_valid_d = 1'b0;
            tapein_d     = 1'b0;
            done_d       = 1'b0;
        end
    end

    // NOTE: non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            read_q       <= 1'b0;
            pf_pend_q    <= 1'b0;
            hold_valid_q <= 1'b0;
            bit_idx_q    <= 3'd7;
            half_q       <= 1'b0;
            cnt_q        <= '0;
            tapein_q     <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            read_q       <= read_d;
            pf_pend_q    <= pf_pend_d;
            hold_valid_q <= hold_valid_d;
            bit_idx_q    <= bit_idx_d;
            half_q       <= half_d;
            cnt_q        <= cnt_d;
            tapein_q     <= tapein_d;
            done_q       <= done_d;
        end
    end

    // NOTE: pure data registers need no reset; their valid flags and the FSM guard every use.
    always_ff @(posedge clk) begin
        len_q   <= len_d;
        hold_q  <= hold_d;
        shift_q <= shift_d;
    end

    assign buff_addr = addr_q;
    assign buff_read = read_q;
    assign tapein    = tapein_q;
    assign done      = done_q;
    assign active    = play && (state_q == S_PLAY || state_q == S_WAIT);

endmodule

// File: tb/tb_tape_player.sv
// Directed bench for tape_player with HALF_DIV=4 and a small SDRAM responder model.
module tb_tape_player;

    localparam int HD = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        play;
    logic        rewind;
    logic [19:0] tape_size;
    logic [19:0] buff_addr;
    logic        buff_read;
    logic        buff_ack;
    logic [7:0]  buff_din;
    logic        tapein;
    logic        active;
    logic        done;

    always #5 clk = ~clk;

    tape_player #(.HALF_DIV(HD)) dut (
        .clk       (clk),
        .reset     (reset),
        .play      (play),
        .rewind    (rewind),
        .tape_size (tape_size),
        .buff_addr (buff_addr),
        .buff_read (buff_read),
        .buff_ack  (buff_ack),
        .buff_din  (buff_din),
        .tapein    (tapein),
        .active    (active),
        .done      (done)
    );

    logic [7:0]  mem [0:3];
    int          delay0;
    int          delay1;
    int          wait_cnt;
    int          n_acks;
    logic [19:0] last_ack_addr;
    int          n_checks = 0;
    int          n_fail   = 0;

    // Halves of each byte, MSB-first, first half = ~bit, second half = bit.
    localparam logic [15:0] HALVES_A5 = 16'b0110_0110_1001_1001;
    localparam logic [15:0] HALVES_FF = 16'b0101_0101_0101_0101;
    localparam logic [15:0] HALVES_00 = 16'b1010_1010_1010_1010;

    // Responder: acks a held request after a per-address delay, on the falling edge.
    initial begin
        buff_ack = 1'b0;
        buff_din = 8'h00;
        wait_cnt = 0;
        n_acks = 0;
        last_ack_addr = '0;
        forever begin
            @(negedge clk);
            if (buff_ack) begin
                buff_ack = 1'b0;
            end else if (buff_read) begin
                if (wait_cnt >= ((buff_addr == 20'd1) ? delay1 : delay0)) begin
                    buff_ack = 1'b1;
                    buff_din = mem[buff_addr[1:0]];
                    wait_cnt = 0;
                    n_acks++;
                    last_ack_addr = buff_addr;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) begin
            tick();
            check("rst_read", buff_read, 1'b0);
        end
        check("rst_addr", buff_addr, 20'd0);
        check("rst_tapein", tapein, 1'b0);
        check("rst_active", active, 1'b0);
        check("rst_done", done, 1'b0);
        reset = 1'b0;
        n_acks = 0;
    endtask

    // Returns just after the edge that consumed an ack (the first cycle of a byte).
    task automatic wait_ack(input string tag);
        bit seen = 1'b0;
        for (int n = 0; n < 400 && !seen; n++) begin
            tick();
            seen = buff_ack;
        end
        check({tag, "_ack_seen"}, seen, 1'b1);
    endtask

    task automatic check_byte(input string tag, input logic [15:0] halves);
        for (int i = 0; i < 16; i++) begin
            for (int c = 0; c < HD; c++) begin
                check(tag, tapein, halves[15 - i]);
                if (i == 15 && c == HD - 1) check({tag, "_done_early"}, done, 1'b0);
                tick();
            end
        end
    endtask

    initial begin
        int waited;
        int off;
        reset = 1'b1;
        play = 1'b0;
        rewind = 1'b0;
        tape_size = 20'd1;
        delay0 = 3;
        delay1 = 0;
        mem[0] = 8'hA5; mem[1] = 8'h00; mem[2] = 8'h00; mem[3] = 8'h00;

        // Reset held with play high: nothing moves.
        play = 1'b1;
        do_reset();

        // Single byte 0xA5, ack three cycles after the request.
        tick();
        check("single_read_rise", buff_read, 1'b1);
        check("single_addr", buff_addr, 20'd0);
        wait_ack("single");
        check("single_read_drop", buff_read, 1'b0);
        check("single_active", active, 1'b1);
        check_byte("single_b0", HALVES_A5);
        check("single_done", done, 1'b1);
        check("single_end_tapein", tapein, 1'b0);
        check("single_end_active", active, 1'b0);
        check("single_one_read", n_acks, 1);
        tick();
        check("single_no_reread", buff_read, 1'b0);

        // Gapless two-byte tape, immediate acks.
        play = 1'b0;
        tape_size = 20'd2;
        mem[0] = 8'hFF; mem[1] = 8'h00;
        delay0 = 0; delay1 = 0;
        do_reset();
        play = 1'b1;
        wait_ack("gapless");
        check_byte("gapless_b0", HALVES_FF);
        check("gapless_prefetch_cnt", n_acks, 2);
        check("gapless_prefetch_addr", last_ack_addr, 20'd1);
        check_byte("gapless_b1", HALVES_00);
        check("gapless_done", done, 1'b1);
        check("gapless_reads", n_acks, 2);

        // Underrun: byte 1 arrives 100 cycles late; tapein holds the last level.
        play = 1'b0;
        delay1 = 100;
        do_reset();
        play = 1'b1;
        wait_ack("underrun");
        check_byte("underrun_b0", HALVES_FF);
        waited = 0;
        while (!buff_ack && waited < 300) begin
            check("underrun_hold", tapein, 1'b1);
            check("underrun_active", active, 1'b1);
            tick();
            waited++;
        end
        check("underrun_ack_seen", buff_ack, 1'b1);
        check("underrun_gap", waited > 0, 1'b1);
        check_byte("underrun_b1", HALVES_00);
        check("underrun_done", done, 1'b1);

        // Pause for 20 cycles during bit 3 of a single 0xA5 byte.
        play = 1'b0;
        tape_size = 20'd1;
        mem[0] = 8'hA5;
        delay0 = 0;
        do_reset();
        play = 1'b1;
        wait_ack("pause");
        for (off = 0; off < 34; off++) begin
            check("pause_pre", tapein, HALVES_A5[15 - off / HD]);
            tick();
        end
        play = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            check("pause_frozen", tapein, 1'b1);
            check("pause_active", active, 1'b0);
        end
        play = 1'b1;
        off = 54;
        while (!done && off < 200) begin
            tick();
            off++;
        end
        check("pause_done_cycle", off, 64 + 20);

        // Rewind from END together with play: IDLE first, restart on the next edge.
        rewind = 1'b1;
        tick();
        rewind = 1'b0;
        check("rewind_done", done, 1'b0);
        check("rewind_read", buff_read, 1'b0);
        check("rewind_tapein", tapein, 1'b0);
        tick();
        check("restart_read", buff_read, 1'b1);
        check("restart_addr", buff_addr, 20'd0);

        // Rewind collides with the ack of that fetch; the ack must be ignored.
        rewind = 1'b1;
        tick();
        rewind = 1'b0;
        play = 1'b0;
        tape_size = 20'd0;
        check("rewind_ack_read", buff_read, 1'b0);
        check("rewind_ack_tapein", tapein, 1'b0);
        play = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("empty_read", buff_read, 1'b0);
            check("empty_active", active, 1'b0);
            check("empty_done", done, 1'b0);
        end

        // Reset in the middle of an outstanding fetch.
        tape_size = 20'd1;
        delay0 = 50;
        tick();
        check("midfetch_read", buff_read, 1'b1);
        reset = 1'b1;
        tick();
        check("midfetch_reset_read", buff_read, 1'b0);
        reset = 1'b0;
        play = 1'b0;
        repeat (3) begin
            tick();
            check("midfetch_idle_read", buff_read, 1'b0);
            check("midfetch_idle_tapein", tapein, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
